serial_add_ctrl: RTL

- Bit-serial add/subtract controller that time-shares one 1-bit full-adder cell across WIDTH cycles to produce a WIDTH-bit result.
- The cell is an instance of the existing `adder` module (ports A, B, Cin, Sum, Cout).
- The block owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- It sits between a requester that supplies operands and the adder cell.

---
 rtl/serial_add_ctrl_pkg.sv | 16 +
 rtl/adder.sv | 14 +
 rtl/serial_add_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// controller state encoding and the default operand width.
package serial_add_ctrl_pkg;

    // Default operand/result width in bits (must be at least 2).
    localparam int DEFAULT_WIDTH = 8;

    // Controller states. The spare code 2'd3 is never entered normally
    // and falls back to IDLE if it ever appears.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// Single-bit full-adder cell. It is time-shared by the serial controller,
// which presents one bit pair per cycle.
module adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. One full-adder cell is reused for
// WIDTH cycles, LSB first. The controller owns the operand and result
// shift registers, the carry flop, the bit counter and the
// start/busy/done handshake.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Controller state and registered handshake outputs.
    state_t             r_state;
    state_t             w_state_next;
    logic               r_busy;
    logic               r_done;

    // Serial datapath.
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    // Holds the result bits produced so far. Only WIDTH-1 bits are needed:
    // the last bit comes straight from the cell on the final edge.
    logic [WIDTH-2:0]   r_s_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    // Published result, held between completions.
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    // Full-adder cell outputs and derived control.
    logic               w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_s_cat;

    adder adder0 (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Cin  (r_carry),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    // Newest result bit joins at the top; on the last bit this is the
    // complete result with bit 0 (produced first) at the bottom.
    assign w_s_cat = {w_sum, r_s_sr};

    // The final bit is being processed on this edge.
    assign w_last = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state logic and start acceptance (IDLE or DONE only).
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register; busy/done are registered copies of the next state
    // so they line up exactly with SHIFT and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_SHIFT);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Operand load, per-bit shifting and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1; the add-mode carry-in is ignored.
            r_a_sr  <= a;
            r_b_sr  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_s_sr  <= w_s_cat[WIDTH-1:1];
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                // r_carry is the carry into the MSB at this point, so the
                // signed overflow is that carry XOR the carry out.
                r_sum  <= w_s_cat;
                r_cout <= w_cout;
                r_ovf  <= r_carry ^ w_cout;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
